inst_fetch_unit: RTL



---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_fifo.sv | 71 +++++++
 rtl/inst_fetch_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_unit_pkg : shared constants and FIFO entry type for fetch |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package inst_fetch_unit_pkg;

  localparam int          INST_W         = 32;
  localparam int          PC_MAX_W       = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  // pc is stored at full width; narrower PCs are zero-extended into it
  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : DEPTH-entry synchronous FIFO with clear and count       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // clear dominates both push and pop in the same cycle
  assign w_do_push = push & ~clear;
  assign w_do_pop  = pop & ~clear & (r_count != '0);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_fetch_unit : PC, block-RAM fetch issue and buffered delivery.   |
// | FETCH_SINGLE_STEP_EN adds a 'step' input gating each issue.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                MEM_AW   = 10,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clk,
  input  logic              RST,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_ce,
  output logic [MEM_AW-1:0] inst_addr,
  input  logic [INST_W-1:0] inst_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              misalign
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_issue_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_hold_pc;
  logic [INST_W-1:0] r_hold_inst;

  logic [CNT_W-1:0]  w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic              w_head_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_kill;
  logic              w_grant;
  logic              w_issue;
  logic [OCC_W-1:0]  w_occ;
  logic [ADDR_W-1:0] w_target;

`ifdef FETCH_SINGLE_STEP_EN
  logic r_token;

  // a step arriving while a token is pending is simply dropped
  always_ff @(posedge clk) begin
    if (RST || redirect_valid) begin
      r_token <= 1'b0;
    end else if (w_issue) begin
      r_token <= 1'b0;
    end else if (step) begin
      r_token <= 1'b1;
    end
  end

  assign w_grant = r_token;
`else
  assign w_grant = 1'b1;
`endif

  assign w_head_valid = (w_count != '0);
  assign w_pop        = w_head_valid & inst_ready & ~redirect_valid;

  // With 1-cycle memory latency the in-flight read returns in the redirect
  // cycle itself, so killing it means suppressing that cycle's push.
  assign w_kill       = redirect_valid;
  assign w_push       = r_inflight & ~w_kill;

  // Credit check counts slots already owed to the in-flight read
  assign w_occ   = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue = ~RST & ~redirect_valid & w_grant & (w_occ < OCC_W'(DEPTH));

  assign w_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.pc   = PC_MAX_W'(r_issue_pc);
    w_push_entry.inst = inst_rdata;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_pc       <= RESET_PC;
      r_issue_pc <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      if (w_issue) begin
        r_issue_pc <= r_pc;
      end
    end
  end

  // Last delivered head, shown while the FIFO is empty
  always_ff @(posedge clk) begin
    if (RST) begin
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
    end else if (w_head_valid) begin
      r_hold_pc   <= ADDR_W'(w_head.pc);
      r_hold_inst <= w_head.inst;
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (RST),
    .clear      (redirect_valid),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count)
  );

  assign inst_ce    = w_issue;
  assign inst_addr  = RST ? '0 : r_pc[MEM_AW+1:2];
  assign inst_valid = w_head_valid;
  assign inst       = w_head_valid ? w_head.inst : r_hold_inst;
  assign inst_pc    = w_head_valid ? ADDR_W'(w_head.pc) : r_hold_pc;
  assign misalign   = ~RST & redirect_valid & (redirect_pc[1:0] != 2'b00);

endmodule : inst_fetch_unit
`default_nettype wire
